// File: rtl/multicycle_seq.sv
// Multicycle CPU control sequencer.
// Drives the FETCH/DECODE/EXEC/MEM/WB/HALT sequence for a shared-memory-port
// datapath, watches memory accesses for a bus timeout and counts retired
// instructions. Strobes are decoded from the current state, opcode and inputs.
module multicycle_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  // The access times out on the edge at which the count would reach TIMEOUT.
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC,
    C_SYS,
    C_BAD
  } cls_t;

  state_t        state;
  state_t        state_nxt;
  cls_t          cls;
  logic [WW-1:0] wait_cnt;
  logic          wait_expired;
  logic          set_bus_err;
  logic          set_illegal;

  // Classify the opcode into an instruction class.
  always_comb begin
    cls = C_BAD;
    case (opcode)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1110011: cls = C_SYS;
      default:    cls = C_BAD;
    endcase
  end

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Decode strobes and next state from state, class and inputs.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    alu_op      = 2'b00;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    state_nxt   = state;
    set_bus_err = 1'b0;
    set_illegal = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          state_nxt = DECODE;
        end else if (wait_expired) begin
          state_nxt   = HALT;
          set_bus_err = 1'b1;
        end
      end

      DECODE: begin
        case (cls)
          C_SYS:   state_nxt = HALT;
          C_BAD: begin
            state_nxt   = HALT;
            set_illegal = 1'b1;
          end
          default: state_nxt = EXEC;
        endcase
      end

      EXEC: begin
        state_nxt = WB;
        case (cls)
          C_R: alu_op = 2'b10;
          C_I: begin
            alu_src_b = 1'b1;
            alu_op    = 2'b10;
          end
          C_LOAD, C_STORE: begin
            alu_src_b = 1'b1;
            state_nxt = MEM;
          end
          C_BRANCH: begin
            alu_op    = 2'b01;
            pc_write  = 1'b1;
            pc_src    = br_taken ? 2'b01 : 2'b00;
            state_nxt = FETCH;
          end
          C_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          C_JALR: alu_src_b = 1'b1;
          default: ;
        endcase
      end

      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_write  = 1'b1;
            state_nxt = FETCH;
          end else begin
            mdr_write = 1'b1;
            state_nxt = WB;
          end
        end else if (wait_expired) begin
          state_nxt   = HALT;
          set_bus_err = 1'b1;
        end
      end

      WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_nxt = FETCH;
        case (cls)
          C_LOAD: wb_sel = 2'b01;
          C_LUI:  wb_sel = 2'b11;
          C_JAL: begin
            wb_sel = 2'b10;
            pc_src = 2'b01;
          end
          C_JALR: begin
            wb_sel = 2'b10;
            pc_src = 2'b10;
          end
          default: ;
        endcase
      end

      default: state_nxt = HALT;
    endcase

    // Reset aborts any access at once: no strobe may leak while rst is high.
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      addr_sel    = 1'b0;
      ir_write    = 1'b0;
      mdr_write   = 1'b0;
      reg_write   = 1'b0;
      wb_sel      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = 2'b00;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      set_bus_err = 1'b0;
      set_illegal = 1'b0;
    end
  end

  // State, wait counter, sticky status flags and retired-instruction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      instret  <= '0;
    end else begin
      state <= state_nxt;
      // Counter returns to zero whenever no access is stalling, so it is
      // already clear on every entry to FETCH or MEM.
      if (mem_req && !mem_ready) begin
        wait_cnt <= wait_cnt + WW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (pc_write) begin
        instret <= instret + 32'd1;
      end
      if (state_nxt == HALT) begin
        halted <= 1'b1;
      end
      if (set_bus_err) begin
        bus_err <= 1'b1;
      end
      if (set_illegal) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: each instruction is expanded into
// its expected per-cycle strobe trace from the instruction-class rules.
module tb_multicycle_seq;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_src;
  } strobes_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, mdr_write, reg_write;
  logic [1:0]  wb_sel;
  logic        alu_src_a, alu_src_b;
  logic [1:0]  alu_op;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        halted, illegal, bus_err;
  logic [31:0] instret;

  strobes_t    obs;
  logic [31:0] model_ret = '0;
  int          tests = 0;
  int          fails = 0;

  multicycle_seq #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_write(pc_write),
    .pc_src(pc_src), .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, addr_sel, ir_write, mdr_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op, pc_write, pc_src};

  task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_flags(input string tag, input logic h, input logic i, input logic b);
    check32(tag, {29'd0, halted, illegal, bus_err}, {29'd0, h, i, b});
  endtask

  // Called just after a falling edge: drive, check, then advance one cycle.
  task automatic step(input string tag, input strobes_t e, input logic rdy);
    mem_ready = rdy;
    #1;
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    check32({tag, "_instret"}, instret, model_ret);
    if (e.pc_write) model_ret = model_ret + 32'd1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check32("reset_strobes", 32'(obs), 32'd0);
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    check32("reset_instret", instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_ret = '0;
  endtask

  task automatic fetch(input int fw);
    strobes_t e;
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1'b1;
      step("fetch_wait", e, 1'b0);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
    step("fetch_done", e, 1'b1);
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic run_instr(input logic [6:0] op, input logic br, input int fw, input int mw);
    strobes_t e;
    opcode   = op;
    br_taken = br;
    fetch(fw);
    e = '0;
    step("decode", e, 1'($urandom));
    e = '0;
    case (op)
      OP_R:     e.alu_op = 2'b10;
      OP_I:     begin e.alu_src_b = 1'b1; e.alu_op = 2'b10; end
      OP_LOAD, OP_STORE, OP_JALR: e.alu_src_b = 1'b1;
      OP_BR:    begin e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = br ? 2'b01 : 2'b00; end
      OP_AUIPC: begin e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; end
      default:  ;
    endcase
    step("exec", e, 1'($urandom));
    if (op == OP_BR) return;
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < mw; i++) begin
        e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (op == OP_STORE);
        step("mem_wait", e, 1'b0);
      end
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (op == OP_STORE);
      if (op == OP_STORE) e.pc_write = 1'b1;
      else                e.mdr_write = 1'b1;
      step("mem_done", e, 1'b1);
      if (op == OP_STORE) return;
    end
    e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1;
    case (op)
      OP_LOAD: e.wb_sel = 2'b01;
      OP_LUI:  e.wb_sel = 2'b11;
      OP_JAL:  begin e.wb_sel = 2'b10; e.pc_src = 2'b01; end
      OP_JALR: begin e.wb_sel = 2'b10; e.pc_src = 2'b10; end
      default: ;
    endcase
    step("wb", e, 1'($urandom));
  endtask

  initial begin
    logic [6:0] ops [9];
    strobes_t   e;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    @(negedge clk);
    do_reset();

    // ADDI, memory always ready: four cycles, one retired instruction.
    run_instr(OP_I, 1'b0, 0, 0);
    check32("addi_instret", instret, 32'd1);

    // LW with three wait cycles in MEM.
    run_instr(OP_LOAD, 1'b0, 0, 3);
    check32("lw_instret", instret, 32'd2);

    // Branch taken then not taken.
    run_instr(OP_BR, 1'b1, 0, 0);
    run_instr(OP_BR, 1'b0, 0, 0);
    check32("beq_instret", instret, 32'd4);

    // Random instruction mix with wait states up to one short of timeout.
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 8)], 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    check_flags("random_flags", 1'b0, 1'b0, 1'b0);

    // Reset pulsed while a store is waiting in MEM.
    opcode = OP_STORE;
    fetch(0);
    e = '0; step("sw_decode", e, 1'b0);
    e = '0; e.alu_src_b = 1'b1; step("sw_exec", e, 1'b0);
    e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    step("sw_mem_wait", e, 1'b0);
    do_reset();
    run_instr(OP_I, 1'b0, 0, 0);
    check32("after_rst_instret", instret, 32'd1);

    // Illegal opcode halts after DECODE and stays quiet.
    opcode = 7'b0000000;
    fetch(0);
    e = '0; step("ill_decode", e, 1'b1);
    for (int i = 0; i < 10; i++) begin
      e = '0; step("ill_quiet", e, 1'($urandom));
      check_flags("ill_flags", 1'b1, 1'b1, 1'b0);
    end

    // System opcode halts without flagging illegal.
    do_reset();
    opcode = OP_SYS;
    fetch(1);
    e = '0; step("sys_decode", e, 1'b0);
    e = '0; step("sys_quiet", e, 1'b1);
    check_flags("sys_flags", 1'b1, 1'b0, 1'b0);

    // Fetch never answered: bus error after four wait cycles.
    do_reset();
    opcode = OP_I;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.mem_req = 1'b1;
      step("fto_wait", e, 1'b0);
    end
    e = '0; step("fto_halt", e, 1'b1);
    check_flags("fto_flags", 1'b1, 1'b0, 1'b1);
    check32("fto_instret", instret, 32'd0);

    // Load never answered in MEM: bus error as well.
    do_reset();
    opcode = OP_LOAD;
    fetch(0);
    e = '0; step("mto_decode", e, 1'b0);
    e = '0; e.alu_src_b = 1'b1; step("mto_exec", e, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
      step("mto_wait", e, 1'b0);
    end
    e = '0; step("mto_halt", e, 1'b1);
    check_flags("mto_flags", 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
